// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-word layout, NOP opcode, fetch FSM states.
// The fetch wait-state feature is selected with the FETCH_WAIT_EN macro.
package cpu_pkg;

    localparam int CTRL_W = 16;

    // Bit positions inside the control word.
    localparam int PCO = 0;  // PC drives the shared bus
    localparam int MAI = 1;  // load MAR
    localparam int MO  = 2;  // memory read
    localparam int II  = 3;  // load instruction register
    localparam int OI  = 4;  // load operand register
    localparam int PCS = 5;  // increment PC
    localparam int J   = 6;  // jump: PC <= operand register

    typedef logic [CTRL_W-1:0] control_signals_t;

    localparam logic [7:0] NOP = 8'h00;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read port of the fetch unit: request/address out, data/ack back.
interface fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, output addr, input rdata, input ack);
    modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/fetch_unit_program_counter.sv
// Program counter: synchronous reset, jump load (priority) and wrapping increment.
module program_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q, pc_d;

    // Next PC: jump beats increment; the add wraps naturally at 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    // PC register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch datapath: PC, MAR, instruction/operand registers and the
// memory read FSM. Define FETCH_WAIT_EN to enable the mem_ack handshake and
// the WAIT state; without it every read completes in one cycle.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  control_signals_t  ctrl,
    fetch_unit_if.master      mem,
    output logic [DATA_W-1:0] ireg,
    output logic [DATA_W-1:0] oreg,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              stall
);
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ireg_q, ireg_d;
    logic [DATA_W-1:0] oreg_q, oreg_d;
    logic [ADDR_W-1:0] pc_val;
    logic              req;
    logic              rd_done;
    logic              step_go;

    // Only a subset of the control word concerns fetch.
    logic unused_ctrl;
    assign unused_ctrl = ^ctrl;

`ifdef FETCH_WAIT_EN
    fetch_state_e state_q, state_d;

    // Read FSM: request while MO is set in IDLE or while waiting for ack.
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (ctrl[MO]) begin
                    req = 1'b1;
                    if (!mem.ack) state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                req = 1'b1;
                if (mem.ack) state_d = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign rd_done = req & mem.ack;
    assign stall   = req & ~mem.ack;

    // The control logic must hold its step while the fetch is stalled.
    ctrl_stable_during_stall: assert property (
        @(posedge clk) disable iff (rst) stall |=> (ctrl == $past(ctrl))
    );
`else
    // Single-cycle memory: every MO step completes at the next edge.
    logic unused_ack;
    assign unused_ack = mem.ack;
    assign req        = ctrl[MO];
    assign rd_done    = ctrl[MO];
    assign stall      = 1'b0;
`endif

    // A step takes effect only on the edge where it is not stalled.
    assign step_go = ~stall;

    // MAR and capture registers next-state.
    always_comb begin
        mar_d  = mar_q;
        ireg_d = ireg_q;
        oreg_d = oreg_q;
        if (step_go && ctrl[MAI]) begin
            mar_d = ctrl[PCO] ? pc_val : ADDR_W'(oreg_q);
        end
        if (rd_done && ctrl[II]) ireg_d = mem.rdata;
        if (rd_done && ctrl[OI]) oreg_d = mem.rdata;
    end

    // MAR, instruction and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mar_q  <= '0;
            ireg_q <= DATA_W'(NOP);
            oreg_q <= '0;
        end else begin
            mar_q  <= mar_d;
            ireg_q <= ireg_d;
            oreg_q <= oreg_d;
        end
    end

    program_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (step_go & ctrl[J]),
        .load_val_i (ADDR_W'(oreg_q)),
        .inc_i      (step_go & ctrl[PCS]),
        .pc_o       (pc_val)
    );

    assign mem.req  = req;
    assign mem.addr = mar_q;
    assign ireg     = ireg_q;
    assign oreg     = oreg_q;
    assign pc       = pc_val;
    assign bus_out  = pc_val;
    assign bus_oe   = ctrl[PCO];
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed fetch sequence, wrap, jump
// priority, wait states and reset-in-WAIT (when FETCH_WAIT_EN is defined),
// then randomized steps against a step-level reference model.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst;
    control_signals_t ctrl;
    logic [DW-1:0]    ireg, oreg;
    logic [AW-1:0]    pc, bus_out;
    logic             bus_oe, stall;

    fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    logic [DW-1:0] memory [256];

    int checks = 0;
    int errors = 0;

    // Reference model state: architectural values after the last completed step.
    int m_pc, m_mar, m_ireg, m_oreg;

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl    (ctrl),
        .mem     (mem_bus.master),
        .ireg    (ireg),
        .oreg    (oreg),
        .pc      (pc),
        .bus_out (bus_out),
        .bus_oe  (bus_oe),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    assign mem_bus.rdata = memory[mem_bus.addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic control_signals_t cw(input bit pco, input bit mai, input bit mo,
                                            input bit ii, input bit oi, input bit pcs,
                                            input bit j);
        control_signals_t c;
        c      = '0;
        c[PCO] = pco;
        c[MAI] = mai;
        c[MO]  = mo;
        c[II]  = ii;
        c[OI]  = oi;
        c[PCS] = pcs;
        c[J]   = j;
        return c;
    endfunction

    function automatic void model_reset();
        m_pc   = 0;
        m_mar  = 0;
        m_ireg = 0;
        m_oreg = 0;
    endfunction

    // One completed control step, straight from the fetch rules.
    function automatic void model_step(input control_signals_t c);
        int old_pc   = m_pc;
        int old_mar  = m_mar;
        int old_oreg = m_oreg;
        if (c[MAI]) m_mar = c[PCO] ? old_pc : old_oreg;
        if (c[MO]) begin
            if (c[II]) m_ireg = int'(memory[old_mar]);
            if (c[OI]) m_oreg = int'(memory[old_mar]);
        end
        if (c[J])        m_pc = old_oreg;
        else if (c[PCS]) m_pc = (old_pc + 1) % 256;
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        ctrl        = '0;
        mem_bus.ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Present one control step, hold it through 'waits' stall cycles (MO only,
    // wait build only), then compare against the model after the step edge.
    task automatic do_step(input string tag, input control_signals_t c,
                           input int waits, output int stall_cycles);
        int left;
        left = c[MO] ? waits : 0;
`ifndef FETCH_WAIT_EN
        left = 0;
`endif
        stall_cycles = 0;
        ctrl = c;
        for (int k = 0; k <= left; k++) begin
            mem_bus.ack = c[MO] ? (k == left) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stall) stall_cycles++;
            check({tag, " stall"},   32'(stall),       32'(k < left));
            check({tag, " mem_req"}, 32'(mem_bus.req), 32'(c[MO]));
            if (c[MO]) check({tag, " mem_addr"}, 32'(mem_bus.addr), 32'(m_mar));
            check({tag, " bus_oe"},  32'(bus_oe),  32'(c[PCO]));
            check({tag, " bus_out"}, 32'(bus_out), 32'(m_pc));
            check({tag, " pc hold"}, 32'(pc),      32'(m_pc));
            check({tag, " ir hold"}, 32'(ireg),    32'(m_ireg));
            @(posedge clk);
            #1;
        end
        mem_bus.ack = 1'b0;
        model_step(c);
        check({tag, " pc"},   32'(pc),           32'(m_pc));
        check({tag, " ireg"}, 32'(ireg),         32'(m_ireg));
        check({tag, " oreg"}, 32'(oreg),         32'(m_oreg));
        check({tag, " mar"},  32'(mem_bus.addr), 32'(m_mar));
    endtask

    initial begin
        int sc;
        control_signals_t rc;

        for (int i = 0; i < 256; i++) memory[i] = '0;
        memory[0] = 8'h3A;
        memory[1] = 8'h7F;

        // Reset, then idle.
        do_reset();
        @(negedge clk);
        check("reset pc",      32'(pc),           32'h0);
        check("reset ireg",    32'(ireg),         32'h0);
        check("reset oreg",    32'(oreg),         32'h0);
        check("reset mem_req", 32'(mem_bus.req),  32'h0);
        check("reset stall",   32'(stall),        32'h0);
        check("reset addr",    32'(mem_bus.addr), 32'h0);
        @(posedge clk);
        #1;

        // Zero-wait fetch of instruction and operand.
        do_step("f0 pco_mai",   cw(1,1,0,0,0,0,0), 0, sc);
        do_step("f1 mo_ii_pcs", cw(0,0,1,1,0,1,0), 0, sc);
        do_step("f2 pco_mai",   cw(1,1,0,0,0,0,0), 0, sc);
        do_step("f3 mo_oi_pcs", cw(0,0,1,0,1,1,0), 0, sc);
        check("fetch ireg", 32'(ireg), 32'h3A);
        check("fetch oreg", 32'(oreg), 32'h7F);
        check("fetch pc",   32'(pc),   32'h2);

`ifdef FETCH_WAIT_EN
        // Three-cycle wait on an instruction read.
        memory[2] = 8'h55;
        do_step("w0 pco_mai",   cw(1,1,0,0,0,0,0), 0, sc);
        do_step("w1 mo_ii_pcs", cw(0,0,1,1,0,1,0), 3, sc);
        check("wait stall cycles", 32'(sc),   32'd3);
        check("wait ireg",         32'(ireg), 32'h55);
        check("wait pc",           32'(pc),   32'h3);
`endif

        // PC wrap: load 0xFF via jump, then increment.
        memory[m_pc] = 8'hFF;
        do_step("p0 pco_mai",   cw(1,1,0,0,0,0,0), 0, sc);
        do_step("p1 mo_oi_pcs", cw(0,0,1,0,1,1,0), 1, sc);
        do_step("p2 jump",      cw(0,0,0,0,0,0,1), 0, sc);
        check("jump to ff", 32'(pc), 32'hFF);
        do_step("p3 pcs wrap",  cw(0,0,0,0,0,1,0), 0, sc);
        check("pc wrap", 32'(pc), 32'h00);

        // Operand addressing (MAR <= oreg), then J beats PCS.
        memory[255] = 8'h40;
        do_step("j0 mai oreg", cw(0,1,0,0,0,0,0), 0, sc);
        check("mar from oreg", 32'(mem_bus.addr), 32'hFF);
        do_step("j1 mo_oi",    cw(0,0,1,0,1,0,0), 2, sc);
        do_step("j2 j_pcs",    cw(0,0,0,0,0,1,1), 0, sc);
        check("j beats pcs", 32'(pc), 32'h40);

`ifdef FETCH_WAIT_EN
        // Reset while waiting; a late ack must be ignored.
        memory[8'h40] = 8'h99;
        do_step("r0 pco_mai", cw(1,1,0,0,0,0,0), 0, sc);
        ctrl        = cw(0,0,1,1,0,1,0);
        mem_bus.ack = 1'b0;
        @(negedge clk);
        check("rw stall before", 32'(stall), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rw in wait req", 32'(mem_bus.req), 32'h1);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        ctrl = '0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        mem_bus.ack = 1'b1;
        model_reset();
        @(negedge clk);
        check("rw mem_req", 32'(mem_bus.req), 32'h0);
        check("rw stall",   32'(stall),       32'h0);
        @(posedge clk);
        #1;
        mem_bus.ack = 1'b0;
        check("rw ireg", 32'(ireg), 32'h0);
        check("rw pc",   32'(pc),   32'h0);
`else
        do_reset();
        @(negedge clk);
        check("rst2 pc",   32'(pc),   32'h0);
        check("rst2 ireg", 32'(ireg), 32'h0);
        @(posedge clk);
        #1;
`endif

        // Randomized steps against the model.
        for (int i = 0; i < 256; i++) memory[i] = DW'($urandom);
        for (int n = 0; n < 80; n++) begin
            rc = control_signals_t'($urandom);
            do_step("rand", rc, int'($urandom_range(0, 3)), sc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch datapath directly downstream of the CPU control logic. Decodes the fetch-related bits of the control word (`ctrl`) to manage the program counter (PC) and the memory address register (MAR). It runs memory reads and captures the returned byte into the instruction register (`ireg`) or the operand register (`oreg`), which feed back into the control logic. With wait-state support compiled in, it raises `stall` so the control step counter holds while memory is busy.

## Interface

Parameters:
- `ADDR_W`, default 8: PC/MAR width; the address space wraps at 2^ADDR_W.
- `DATA_W`, default 8: memory word, `ireg` and `oreg` width.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ctrl`  in  CONTROL_SIGNALS: control word; bits used are PCO, MAI, MO, II, OI, PCS and J.
- `mem_rdata`  in  DATA_W: memory read data, valid when `mem_ack` is high.
- `mem_ack`  in  1: memory read complete (used only with FETCH_WAIT_EN).
- `mem_req`  out  1: memory read request.
- `mem_addr`  out  ADDR_W: read address; always equals MAR.
- `ireg`  out  DATA_W: instruction register.
- `oreg`  out  DATA_W: operand register.
- `pc`  out  ADDR_W: current program counter.
- `bus_out`  out  ADDR_W: PC value for the shared bus.
- `bus_oe`  out  1: high when `ctrl[PCO]` is high; combinational.
- `stall`  out  1: control logic must hold its step and `ctrl` while this is high.

## Operation

- Reset values:
  - `pc`, MAR, `ireg`, `oreg` = 0; `ireg` = 0 is NOP.
  - FSM in IDLE.
  - `mem_req` = 0, `stall` = 0.
- PCO+MAI: MAR <= PC at the edge. MAI without PCO: MAR <= `oreg` (operand addressing).
- FSM states: IDLE and WAIT.
  - IDLE with `ctrl[MO]` = 1: `mem_req` = 1 combinationally.
    - If `mem_ack` = 1 in the same cycle, the read completes this edge and the FSM stays in IDLE.
    - Otherwise the FSM goes to WAIT.
  - WAIT: `mem_req` = 1. On `mem_ack` = 1 the read completes and the FSM returns to IDLE.
- Read completion, at the completing edge:
  - `ireg` <= `mem_rdata` if II.
  - `oreg` <= `mem_rdata` if OI.
  - If both II and OI are set, both registers load.
  - PC <= PC+1 if PCS.
- PCS or J without MO: takes effect at the next edge, no memory cycle.
- J: PC <= `oreg`. If J and PCS are active in the same cycle, J wins.
- PC increment wraps from 2^ADDR_W−1 to 0.
- `stall` = `mem_req` & ~`mem_ack`.
- `mem_ack` with no request outstanding is ignored.
- Reset during WAIT: FSM returns to IDLE and `mem_req` drops the next cycle. An ack arriving after reset is ignored.
- `ctrl` changing while `stall` = 1 is a protocol violation; behaviour is undefined and a simulation assertion flags it.

## Timing

- Zero-wait read: request, data capture and PC increment all happen in one cycle.
- N-wait read: `stall` is high for N cycles and the capture happens at the ack edge. The control logic re-presents the same step until `stall` falls.
- `ireg`/`oreg` are visible one cycle after the capturing edge, which is the next control step.
- `mem_addr` is registered (MAR) and stable for the entire request.

## Configuration

- `FETCH_WAIT_EN`:
  - Defined: the `mem_ack` handshake and the WAIT state exist, and `stall` is driven as above.
  - Undefined: `mem_ack` is treated as constant 1, the WAIT state is removed, and `stall` is tied to 0. Every MO step completes in one cycle, matching the single-cycle memory timing the control logic uses.

## Structure

- Shared package `cpu_pkg`:
  - Control bit indices: PCO, MAI, MO, II, OI, PCS, J.
  - CONTROL_SIGNALS.
  - NOP opcode.
  - Fetch FSM state enum.
- Natural sub-module: `program_counter`, holding PC with load (J), increment (PCS), wrap and reset.
- MAR, IR/OR and the FSM stay in `fetch_unit`.

## Test plan

- Reset then idle:
  - `pc` = 0, `ireg` = 0, `oreg` = 0, `mem_req` = 0, `stall` = 0.
- Fetch sequence, memory[0] = 0x3A, memory[1] = 0x7F, zero-wait. Steps: PCO+MAI, then MO+II+PCS, then PCO+MAI, then MO+OI+PCS.
  - `ireg` = 0x3A, `oreg` = 0x7F, `pc` = 2.
  - `mem_addr` = 0 during the first read and 1 during the second.
- FETCH_WAIT_EN defined, ack delayed 3 cycles on MO+II+PCS:
  - `stall` is high for exactly 3 cycles.
  - `ireg` updates and `pc` increments only at the ack edge.
- `pc` = 0xFF with PCS: `pc` = 0x00.
- `oreg` = 0x40 with J and PCS active together: `pc` = 0x40.
- `rst` asserted in WAIT, then ack 1 cycle later:
  - FSM is IDLE, `mem_req` = 0.
  - `ireg` is still 0 and `pc` = 0.
